// File: rtl/udp_pkg.sv
// Shared UDP definitions: header constants, transmit FSM encoding and the
// ones-complement checksum helpers used by both the tx and rx paths.
package udp_pkg;

    localparam int         UDP_HDR_LEN     = 8;
    localparam logic [7:0] IP_PROTO_UDP    = 8'h11;
    localparam int         MIN_PAYLOAD_DEF = 18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSUM,
        ST_FOLD,
        ST_WAIT_ACK,
        ST_SEND_HEAD,
        ST_SEND_DATA,
        ST_SEND_PAD,
        ST_END
    } udp_tx_state_e;

    // 16-bit ones-complement add with end-around carry.
    function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    // Two end-around folds bring any 32-bit sum of 16-bit words into 16 bits.
    function automatic logic [15:0] csum_fold32(input logic [31:0] acc);
        logic [16:0] s1;
        logic [16:0] s2;
        s1 = {1'b0, acc[31:16]} + {1'b0, acc[15:0]};
        s2 = {1'b0, s1[15:0]} + {16'd0, s1[16]};
        return s2[15:0];
    endfunction

    // A computed checksum of zero is transmitted as all-ones.
    function automatic logic [15:0] csum_final(input logic [31:0] acc);
        logic [15:0] c;
        c = ~csum_fold32(acc);
        return (c == 16'h0000) ? 16'hFFFF : c;
    endfunction

endpackage

// File: rtl/Simple_DualRAM.sv
// Simple dual-port byte RAM: port a writes, port b reads with one clock of
// registered read latency.
module Simple_DualRAM #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              wr_en_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] dout_b
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array and read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_a) begin
            mem[addr_a] <= din_a;
        end
        dout_b <= mem[addr_b];
    end

endmodule

// File: rtl/udp_tx.sv
// UDP transmit engine: checksums a payload held in internal RAM, requests the
// IP layer and streams the UDP header plus payload (zero-padded) one byte/clk.
module udp_tx
    import udp_pkg::*;
#(
    parameter logic [15:0] SRC_PORT    = 16'h1F90,
    parameter logic [15:0] DST_PORT    = 16'h1F90,
    parameter int          MAX_PAYLOAD = 1472,
    parameter int          MIN_PAYLOAD = MIN_PAYLOAD_DEF,
    parameter int          ADDR_W      = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              udp_ram_wr_en,
    input  logic [ADDR_W-1:0] udp_ram_wr_addr,
    input  logic [7:0]        udp_ram_wr_data,
    input  logic              udp_send_start,
    input  logic [15:0]       udp_send_data_length,
    input  logic [31:0]       ip_src_addr,
    input  logic [31:0]       ip_dst_addr,
    output logic              udp_tx_ready,
    input  logic              ip_tx_ack,
    output logic [7:0]        udp_tx_data,
    output logic              udp_tx_data_valid,
    output logic              udp_tx_end,
    output logic [15:0]       udp_upper_length,
    output logic              udp_tx_busy
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);
    localparam logic [15:0] MIN_LEN = 16'(MIN_PAYLOAD);
    localparam logic [15:0] HDR_LEN = 16'(UDP_HDR_LEN);

    udp_tx_state_e state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   rx_cnt_q, rx_cnt_d;
    logic          rd_vld_q, rd_vld_d;
    logic [7:0]    hi_byte_q, hi_byte_d;
    logic [31:0]   acc_q, acc_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   upper_len_q, upper_len_d;
    logic [15:0]   csum_q, csum_d;

    logic [ADDR_W-1:0] ram_rd_addr;
    logic [7:0]        ram_rd_data;
    logic              len_ok;
    logic [16:0]       upper_len17;
    logic [31:0]       preload;

    Simple_DualRAM #(
        .DATA_W (8),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en_a (udp_ram_wr_en),
        .addr_a  (udp_ram_wr_addr),
        .din_a   (udp_ram_wr_data),
        .addr_b  (ram_rd_addr),
        .dout_b  (ram_rd_data)
    );

    assign len_ok      = (udp_send_data_length != 16'd0) && (udp_send_data_length <= MAX_LEN);
    assign upper_len17 = {1'b0, udp_send_data_length} + {1'b0, HDR_LEN};

    // UDP length appears twice: once in the pseudo-header, once in the header.
    assign preload = {16'd0, ip_src_addr[31:16]} + {16'd0, ip_src_addr[15:0]}
                   + {16'd0, ip_dst_addr[31:16]} + {16'd0, ip_dst_addr[15:0]}
                   + {24'd0, IP_PROTO_UDP}      + {14'd0, upper_len17, 1'b0}
                   + {16'd0, SRC_PORT}          + {16'd0, DST_PORT};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            rx_cnt_q    <= 16'd0;
            rd_vld_q    <= 1'b0;
            hi_byte_q   <= 8'd0;
            acc_q       <= 32'd0;
            len_q       <= 16'd0;
            upper_len_q <= 16'd0;
            csum_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            rd_vld_q    <= rd_vld_d;
            hi_byte_q   <= hi_byte_d;
            acc_q       <= acc_d;
            len_q       <= len_d;
            upper_len_q <= upper_len_d;
            csum_q      <= csum_d;
        end
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_cnt_d    = rx_cnt_q;
        rd_vld_d    = 1'b0;
        hi_byte_d   = hi_byte_q;
        acc_d       = acc_q;
        len_d       = len_q;
        upper_len_d = upper_len_q;
        csum_d      = csum_q;
        ram_rd_addr = '0;

        case (state_q)
            ST_IDLE: begin
                if (udp_send_start && len_ok) begin
                    state_d     = ST_CSUM;
                    cnt_d       = 16'd0;
                    rx_cnt_d    = 16'd0;
                    len_d       = udp_send_data_length;
                    upper_len_d = upper_len17[15:0];
                    acc_d       = preload;
                end
            end

            ST_CSUM: begin
                if (cnt_q < len_q) begin
                    ram_rd_addr = cnt_q[ADDR_W-1:0];
                    cnt_d       = cnt_q + 16'd1;
                    rd_vld_d    = 1'b1;
                end
                // Even-indexed bytes are held as the high half of the next word.
                if (rd_vld_q) begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                    if (!rx_cnt_q[0]) begin
                        hi_byte_d = ram_rd_data;
                        if (rx_cnt_q == len_q - 16'd1) begin
                            acc_d = acc_q + {16'd0, ram_rd_data, 8'h00};
                        end
                    end else begin
                        acc_d = acc_q + {16'd0, hi_byte_q, ram_rd_data};
                    end
                    if (rx_cnt_q == len_q - 16'd1) begin
                        state_d = ST_FOLD;
                    end
                end
            end

            ST_FOLD: begin
                csum_d  = csum_final(acc_q);
                state_d = ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
                if (ip_tx_ack) begin
                    state_d = ST_SEND_HEAD;
                    cnt_d   = 16'd0;
                end
            end

            ST_SEND_HEAD: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == HDR_LEN - 16'd1) begin
                    ram_rd_addr = '0;
                    cnt_d       = 16'd0;
                    state_d     = ST_SEND_DATA;
                end
            end

            ST_SEND_DATA: begin
                ram_rd_addr = cnt_q[ADDR_W-1:0] + ADDR_W'(1);
                cnt_d       = cnt_q + 16'd1;
                if (cnt_q == len_q - 16'd1) begin
                    state_d = (len_q < MIN_LEN) ? ST_SEND_PAD : ST_END;
                end
            end

            ST_SEND_PAD: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == MIN_LEN - 16'd1) begin
                    state_d = ST_END;
                end
            end

            ST_END: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        udp_tx_data = 8'h00;
        case (state_q)
            ST_SEND_HEAD: begin
                case (cnt_q[2:0])
                    3'd0:    udp_tx_data = SRC_PORT[15:8];
                    3'd1:    udp_tx_data = SRC_PORT[7:0];
                    3'd2:    udp_tx_data = DST_PORT[15:8];
                    3'd3:    udp_tx_data = DST_PORT[7:0];
                    3'd4:    udp_tx_data = upper_len_q[15:8];
                    3'd5:    udp_tx_data = upper_len_q[7:0];
                    3'd6:    udp_tx_data = csum_q[15:8];
                    default: udp_tx_data = csum_q[7:0];
                endcase
            end
            ST_SEND_DATA: udp_tx_data = ram_rd_data;
            default:      udp_tx_data = 8'h00;
        endcase
    end

    assign udp_tx_busy       = (state_q != ST_IDLE);
    assign udp_tx_ready      = (state_q == ST_WAIT_ACK);
    assign udp_tx_data_valid = (state_q == ST_SEND_HEAD) || (state_q == ST_SEND_DATA)
                             || (state_q == ST_SEND_PAD);
    assign udp_tx_end        = ((state_q == ST_SEND_DATA) && (cnt_q == len_q - 16'd1)
                                && (len_q >= MIN_LEN))
                             || ((state_q == ST_SEND_PAD) && (cnt_q == MIN_LEN - 16'd1));
    assign udp_upper_length  = upper_len_q;

endmodule

// File: tb/tb_udp_tx.sv
// Scoreboard bench for udp_tx: stimulus queues the expected byte stream and a
// negedge monitor compares every valid byte and its end flag against it.
module tb_udp_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        udp_ram_wr_en = 1'b0;
    logic [10:0] udp_ram_wr_addr = '0;
    logic [7:0]  udp_ram_wr_data = '0;
    logic        udp_send_start = 1'b0;
    logic [15:0] udp_send_data_length = '0;
    logic [31:0] ip_src_addr = 32'hC0A80002;
    logic [31:0] ip_dst_addr = 32'hC0A80003;
    logic        udp_tx_ready;
    logic        ip_tx_ack = 1'b0;
    logic [7:0]  udp_tx_data;
    logic        udp_tx_data_valid;
    logic        udp_tx_end;
    logic [15:0] udp_upper_length;
    logic        udp_tx_busy;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] pl [0:2047];
    int         checks = 0;
    int         failures = 0;

    udp_tx dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .udp_ram_wr_en        (udp_ram_wr_en),
        .udp_ram_wr_addr      (udp_ram_wr_addr),
        .udp_ram_wr_data      (udp_ram_wr_data),
        .udp_send_start       (udp_send_start),
        .udp_send_data_length (udp_send_data_length),
        .ip_src_addr          (ip_src_addr),
        .ip_dst_addr          (ip_dst_addr),
        .udp_tx_ready         (udp_tx_ready),
        .ip_tx_ack            (ip_tx_ack),
        .udp_tx_data          (udp_tx_data),
        .udp_tx_data_valid    (udp_tx_data_valid),
        .udp_tx_end           (udp_tx_end),
        .udp_upper_length     (udp_upper_length),
        .udp_tx_busy          (udp_tx_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference checksum: plain word sum with repeated folding.
    function automatic logic [15:0] model_csum(input int len);
        logic [31:0] acc;
        logic [7:0]  lo;
        logic [15:0] c;
        acc = ip_src_addr[31:16] + ip_src_addr[15:0] + ip_dst_addr[31:16] + ip_dst_addr[15:0]
            + 32'h11 + 2 * (len + 8) + 2 * 32'h1F90;
        for (int i = 0; i < len; i += 2) begin
            lo  = (i + 1 < len) ? pl[i+1] : 8'h00;
            acc = acc + {16'd0, pl[i], lo};
        end
        while (acc[31:16] != 16'd0) acc = {16'd0, acc[31:16]} + {16'd0, acc[15:0]};
        c = ~acc[15:0];
        return (c == 16'h0000) ? 16'hFFFF : c;
    endfunction

    task automatic write_payload(input int len, input logic [7:0] base, input logic [7:0] step);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            udp_ram_wr_en   = 1'b1;
            udp_ram_wr_addr = 11'(i);
            udp_ram_wr_data = base + 8'(i) * step;
            pl[i]           = udp_ram_wr_data;
        end
        @(negedge clk);
        udp_ram_wr_en = 1'b0;
    endtask

    task automatic push_expected(input int len, input logic [15:0] cs);
        logic [7:0] hdr [8];
        int         total;
        int         idx;
        logic [15:0] ul;
        ul = 16'(len + 8);
        hdr = '{8'h1F, 8'h90, 8'h1F, 8'h90, ul[15:8], ul[7:0], cs[15:8], cs[7:0]};
        total = 8 + ((len > 18) ? len : 18);
        for (int i = 0; i < total; i++) begin
            idx = i - 8;
            sb.push_back('{data: (i < 8) ? hdr[i] : ((idx < len) ? pl[idx] : 8'h00),
                           last: (i == total - 1)});
        end
    endtask

    task automatic kick(input int len);
        @(negedge clk);
        udp_send_start       = 1'b1;
        udp_send_data_length = 16'(len);
        @(negedge clk);
        udp_send_start = 1'b0;
    endtask

    task automatic begin_frame(input int len, input logic [15:0] cs, input int ack_delay,
                               input bit intrude);
        int n;
        bit held;
        push_expected(len, cs);
        kick(len);
        if (intrude) kick(3);
        n = 0;
        while (!udp_tx_ready && n < len + 8) begin
            @(negedge clk);
            n++;
        end
        check("ready_latency", udp_tx_ready, 1);
        check("upper_length", udp_upper_length, 32'(len + 8));
        held = 1'b1;
        repeat (ack_delay) begin
            @(negedge clk);
            if (!udp_tx_ready || udp_tx_data_valid) held = 1'b0;
        end
        check("ready_held_no_valid", held, 1);
        ip_tx_ack = 1'b1;
        @(negedge clk);
        ip_tx_ack = 1'b0;
        check("valid_after_ack", udp_tx_data_valid, 1);
    endtask

    task automatic end_frame(input int len);
        int n;
        int lim;
        n   = 0;
        lim = 12 + ((len > 18) ? len : 18);
        while (sb.size() != 0 && n < lim) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("frame_complete", sb.size(), 0);
        check("busy_on_last", udp_tx_busy, 1);
        @(negedge clk);
        check("busy_after_end", {udp_tx_busy, udp_tx_data_valid}, 2'b10);
        @(negedge clk);
        check("busy_release", udp_tx_busy, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (udp_tx_data_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", udp_tx_data_valid, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("tx_data", udp_tx_data, e.data);
                    check("tx_end", udp_tx_end, e.last);
                end
            end else begin
                check("end_without_valid", udp_tx_end, 0);
            end
        end
    end

    initial begin
        bit quiet;

        #1;
        check("reset_outputs",
              {udp_tx_ready, udp_tx_data, udp_tx_data_valid, udp_tx_end, udp_upper_length, udp_tx_busy},
              '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Frame 1: hand-computed 4-byte payload, padded to 18.
        write_payload(4, 8'h01, 8'h01);
        begin_frame(4, 16'h3B5A, 2, 0);
        end_frame(4);

        // Odd 19-byte payload, no pad.
        write_payload(19, 8'hA0, 8'h0D);
        begin_frame(19, model_csum(19), 2, 0);
        end_frame(19);

        // Illegal lengths and a stray ack while idle are ignored.
        quiet = 1'b1;
        @(negedge clk);
        ip_tx_ack = 1'b1;
        @(negedge clk);
        ip_tx_ack = 1'b0;
        kick(0);
        kick(1473);
        repeat (20) begin
            @(negedge clk);
            if (udp_tx_busy || udp_tx_ready || udp_tx_data_valid) quiet = 1'b0;
        end
        check("illegal_start_ignored", quiet, 1);

        // Ack withheld for 100 clocks.
        begin_frame(19, model_csum(19), 100, 0);
        end_frame(19);

        // Reset in the middle of SEND_DATA.
        write_payload(30, 8'h33, 8'h29);
        begin_frame(30, model_csum(30), 2, 0);
        repeat (12) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {udp_tx_ready, udp_tx_data, udp_tx_data_valid, udp_tx_end, udp_upper_length, udp_tx_busy},
              '0);
        sb.delete();
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (udp_tx_end || udp_tx_busy) quiet = 1'b0;
        end
        check("reset_hold_quiet", quiet, 1);
        rst_n = 1'b1;
        begin_frame(30, model_csum(30), 2, 0);
        end_frame(30);

        // Start while busy is ignored; then back-to-back frames.
        write_payload(40, 8'hF7, 8'h3B);
        begin_frame(40, model_csum(40), 2, 1);
        end_frame(40);
        begin_frame(7, model_csum(7), 2, 0);
        end_frame(7);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog timeout at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
